// File: rtl/sobel_stream_if.sv
// ============================================================================
//  Module      : sobel_stream_if
//  Description : Stream bundle for sobel_stream: pixel input channel and
//                gradient-magnitude output channel, both valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sobel_stream_if #(
    parameter int PIX_W = 8
) ();
    // Pixel input channel
    logic               in_valid;
    logic               in_ready;
    logic [PIX_W-1:0]   in_data;
    // Magnitude output channel (PIX_W+3 bits wide)
    logic               out_valid;
    logic               out_ready;
    logic [PIX_W+2:0]   out_data;
    logic               out_last;

    // Pixel source / result sink side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Edge detector side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

`default_nettype wire

// File: rtl/sobel_stream.sv
// ============================================================================
//  Module      : sobel_stream
//  Description : Streaming 3x3 Sobel edge detector. Raster-order pixels in,
//                |Gx| (+ |Gy|) magnitudes out for fully covered windows only.
//                Two line buffers hold the previous two rows; 3-stage
//                pipeline (window / gradients / magnitude) under one global
//                enable driven by output backpressure.
//                Optional feature macro: SOBEL_GY_EN (adds the Gy kernel).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 7
) (
    input  wire logic       clk,
    input  wire logic       rst,
    sobel_stream_if.slave   bus
);
    localparam int OUT_W = PIX_W + 3;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_COL_TWO  = CW'(2);
    localparam logic [RW-1:0] C_ROW_TWO  = RW'(2);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Pipeline control
    logic                    en;
    logic                    accept;

    // Frame position
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [0:0]              state_q, state_d;
    logic                    run;
    logic                    frame_end;

    // Line buffers and window
    logic [PIX_W-1:0]        lb1_q [IMG_W];
    logic [PIX_W-1:0]        lb2_q [IMG_W];
    logic [PIX_W-1:0]        win_q [3][3];

    // Stage registers
    logic                    v1_q, last1_q;
    logic                    v2_q, last2_q;
    logic signed [OUT_W-1:0] gx_q, gx;
`ifdef SOBEL_GY_EN
    logic signed [OUT_W-1:0] gy_q, gy;
`endif
    logic [OUT_W-1:0]        mag;
    logic                    out_valid_q, out_last_q;
    logic [OUT_W-1:0]        out_data_q;

    function automatic logic signed [OUT_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [OUT_W-1:0] abs_of(input logic signed [OUT_W-1:0] v);
        return v[OUT_W-1] ? OUT_W'(-v) : OUT_W'(v);
    endfunction

    // Whole pipeline advances whenever the output register can move
    always_comb begin
        en     = !out_valid_q || bus.out_ready;
        accept = bus.in_valid && en;
    end

    // Raster counters: advance on accept, wrap at frame end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == C_COL_LAST) begin
                col_d = '0;
                row_d = (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // FSM state register: FILL/RUN tracks the position of the next pixel
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FILL;
        else     state_q <= state_d;
    end

    // FSM next state: RUN once the window at the next position is fully covered
    always_comb begin
        state_d = S_FILL;
        if (row_d >= C_ROW_TWO && col_d >= C_COL_TWO) state_d = S_RUN;
    end

    // FSM outputs: emit flag and frame-final flag for the pixel being accepted
    always_comb begin
        run       = (state_q == S_RUN);
        frame_end = run && (row_q == C_ROW_LAST) && (col_q == C_COL_LAST);
    end

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (contents need no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= bus.in_data;
        end
    end

    // Window: shift left one column per accept, new column enters at j=2
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb2_q[col_q];
            win_q[1][2] <= lb1_q[col_q];
            win_q[2][2] <= bus.in_data;
        end
    end

    // S1 valid: a complete window was formed by this accept
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else if (en) begin
            v1_q    <= accept && run;
            last1_q <= accept && frame_end;
        end
    end

    // Sobel kernels on the current window
    always_comb begin
        gx = (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]))
           - (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]));
`ifdef SOBEL_GY_EN
        gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
`endif
    end

    // S2: register gradients
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            gx_q    <= '0;
`ifdef SOBEL_GY_EN
            gy_q    <= '0;
`endif
        end else if (en) begin
            v2_q    <= v1_q;
            last2_q <= last1_q;
            gx_q    <= gx;
`ifdef SOBEL_GY_EN
            gy_q    <= gy;
`endif
        end
    end

    // Magnitude: L1 norm of the registered gradients, fits OUT_W without saturation
    always_comb begin
`ifdef SOBEL_GY_EN
        mag = abs_of(gx_q) + abs_of(gy_q);
`else
        mag = abs_of(gx_q);
`endif
    end

    // S3: output register, held stable while the sink stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            out_valid_q <= v2_q;
            out_last_q  <= last2_q;
            out_data_q  <= mag;
        end
    end

    // Drive the stream bundle
    always_comb begin
        bus.in_ready  = en;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_last  = out_last_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_sobel_stream.sv
// ============================================================================
//  Module      : tb_sobel_stream
//  Description : Self-checking bench for sobel_stream (PIX_W=8, 4x4 frames).
//                Fixed pattern table, model-checked random frames, and
//                reset / back-to-back frame sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_stream;
    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int FRAME = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sobel_stream_if #(.PIX_W(PIX_W)) bus ();

    sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int stream[$];
    int exp_d[$];
    bit exp_l[$];
    int got_d[$];
    bit got_l[$];
    int first_out_cyc;
    int acc11_cyc;

    typedef struct packed {
        logic [3:0]       pat;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Append one frame of the given pattern to the stream
    task automatic add_frame(input int pat);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                int p;
                case (pat)
                    0:       p = 255;
                    1:       p = 10 * c;
                    2:       p = 10 * r;
                    3:       p = (r == 1 && c == 1) ? 100 : 0;
                    default: p = int'($urandom_range(255));
                endcase
                stream.push_back(p);
            end
    endtask

    // Reference: direct Sobel over each complete frame in the stream
    task automatic build_expected();
        exp_d.delete();
        exp_l.delete();
        for (int f = 0; f < stream.size() / FRAME; f++)
            for (int r = 0; r <= IMG_H - 3; r++)
                for (int c = 0; c <= IMG_W - 3; c++) begin
                    int w [3][3];
                    int gx, gy, m;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            w[i][j] = stream[f * FRAME + (r + i) * IMG_W + (c + j)];
                    gx = (w[0][0] + 2 * w[1][0] + w[2][0]) - (w[0][2] + 2 * w[1][2] + w[2][2]);
                    gy = (w[2][0] + 2 * w[2][1] + w[2][2]) - (w[0][0] + 2 * w[0][1] + w[0][2]);
                    m  = (gx < 0) ? -gx : gx;
`ifdef SOBEL_GY_EN
                    m += (gy < 0) ? -gy : gy;
`endif
                    exp_d.push_back(m);
                    exp_l.push_back(r == IMG_H - 3 && c == IMG_W - 3);
                end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data",  int'(bus.out_data),  0);
        chk("rst_out_last",  int'(bus.out_last),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input int idx, input int vld_pct, input int rdy_pct);
        if (idx < stream.size() && int'($urandom_range(99)) < vld_pct) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(stream[idx]);
        end else begin
            bus.in_valid = 1'b0;
        end
        bus.out_ready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    // Feed the stream, collect results, check output stability under stall
    task automatic run_stream(input int vld_pct, input int rdy_pct, input int drain,
                              input int max_cycles);
        int  idx  = 0;
        int  cyc  = 0;
        int  tail = 0;
        bit  held = 1'b0;
        bit  done = 1'b0;
        int  held_d = 0;
        bit  acc;
        got_d.delete();
        got_l.delete();
        first_out_cyc = -1;
        acc11_cyc     = -1;
        drive(idx, vld_pct, rdy_pct);
        while (cyc < max_cycles && !done) begin
            @(negedge clk);
            if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (held) chk("stall_stable", int'(bus.out_data), held_d);
            held   = bus.out_valid && !bus.out_ready;
            held_d = int'(bus.out_data);
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(int'(bus.out_data));
                got_l.push_back(bus.out_last);
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx == 11) acc11_cyc = cyc;
            end
            cyc++;
            if (idx >= stream.size()) begin
                if (tail >= drain) done = 1'b1;
                tail++;
            end
            drive(idx, vld_pct, rdy_pct);
        end
        chk("run_timeout", int'(done), 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic compare(input string name);
        chk({name, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_last%0d", name, i), int'(got_l[i]), int'(exp_l[i]));
        end
    endtask

    initial begin
        // pattern, expected outputs 0..3
`ifdef SOBEL_GY_EN
        vecs[0] = '{pat: 4'd0, exp: {16'd0,   16'd0,   16'd0,   16'd0}};
        vecs[1] = '{pat: 4'd1, exp: {16'd80,  16'd80,  16'd80,  16'd80}};
        vecs[2] = '{pat: 4'd2, exp: {16'd80,  16'd80,  16'd80,  16'd80}};
        vecs[3] = '{pat: 4'd3, exp: {16'd200, 16'd200, 16'd200, 16'd0}};
`else
        vecs[0] = '{pat: 4'd0, exp: {16'd0,   16'd0,   16'd0,   16'd0}};
        vecs[1] = '{pat: 4'd1, exp: {16'd80,  16'd80,  16'd80,  16'd80}};
        vecs[2] = '{pat: 4'd2, exp: {16'd0,   16'd0,   16'd0,   16'd0}};
        vecs[3] = '{pat: 4'd3, exp: {16'd100, 16'd0,   16'd200, 16'd0}};
`endif

        do_reset();

        // Fixed pattern table: known magnitudes, last flag, latency
        for (int v = 0; v < 4; v++) begin
            stream.delete();
            add_frame(int'(vecs[v].pat));
            run_stream(100, 100, 8, 200);
            chk($sformatf("tab%0d_count", v), got_d.size(), 4);
            for (int k = 0; k < 4 && k < got_d.size(); k++) begin
                chk($sformatf("tab%0d_data%0d", v, k), got_d[k], int'(vecs[v].exp[k]));
                chk($sformatf("tab%0d_last%0d", v, k), int'(got_l[k]), (k == 3) ? 1 : 0);
            end
            chk($sformatf("tab%0d_latency", v), first_out_cyc - acc11_cyc, 3);
        end

        // Random frames against the reference model, random backpressure
        for (int t = 0; t < 6; t++) begin
            stream.delete();
            add_frame(4);
            if (t >= 3) add_frame(4);
            build_expected();
            run_stream((t < 3) ? 100 : 70, 50, 12, 600);
            compare($sformatf("rnd%0d", t));
        end

        // Reset mid-frame (with and without a result in flight), then a ramp frame
        for (int n = 6; n <= 11; n += 5) begin
            stream.delete();
            add_frame(1);
            while (stream.size() > n) void'(stream.pop_back());
            run_stream(100, 100, 0, 100);
            do_reset();
            stream.delete();
            add_frame(1);
            build_expected();
            run_stream(100, 100, 8, 200);
            compare($sformatf("rst_after%0d", n));
        end

        // Two back-to-back ramp frames: 8 results, last on the 4th and 8th
        stream.delete();
        add_frame(1);
        add_frame(1);
        run_stream(100, 100, 8, 300);
        chk("b2b_count", got_d.size(), 8);
        for (int k = 0; k < 8 && k < got_d.size(); k++) begin
            chk($sformatf("b2b_data%0d", k), got_d[k], 80);
            chk($sformatf("b2b_last%0d", k), int'(got_l[k]), (k == 3 || k == 7) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
